// File: rtl/mixer_pkg.sv
// Shared types and arithmetic helpers for the pipeline mixer family.
// Gains are fixed point with (data_width-1-gain_shift) fraction bits.
package mixer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    IN_MUL,
    IN_DONE,
    MIX_FROM,
    MIX_TO,
    OUT_MUL,
    OUT_DONE
  } state_t;

  function automatic int unity_gain(int dw, int gs);
    return 1 << (dw - 1 - gs);
  endfunction

  function automatic int fade_step(int dw, int gs, int fss);
    return unity_gain(dw, gs) >> fss;
  endfunction

  // Clamp a wide signed value into the range of a width-bit signed number.
  function automatic longint saturate(longint v, int width);
    longint hi;
    longint lo;
    hi = (longint'(1) << (width - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/multi_pipeline_mixer_if.sv
// Sample, gain and crossfade signals of the mixer; master drives the inputs,
// slave is the mixer side.
interface multi_pipeline_mixer_if #(
  parameter int data_width  = 16,
  parameter int n_pipelines = 4
);
  localparam int idx_w = $clog2(n_pipelines);

  logic signed [data_width-1:0]         in_sample;
  logic                                 in_sample_valid;
  logic signed [data_width-1:0]         in_sample_out;
  logic                                 in_sample_mixed;
  logic [n_pipelines*data_width-1:0]    out_samples_in;
  logic                                 out_samples_valid;
  logic signed [data_width-1:0]         out_sample;
  logic                                 out_sample_valid;
  logic signed [data_width-1:0]         data_in;
  logic                                 set_input_gain;
  logic                                 set_output_gain;
  logic                                 swap_pipelines;
  logic [idx_w-1:0]                     swap_target;
  logic                                 pipelines_swapping;
  logic [idx_w-1:0]                     current_pipeline;

  modport master (
    output in_sample, in_sample_valid, out_samples_in, out_samples_valid,
           data_in, set_input_gain, set_output_gain, swap_pipelines, swap_target,
    input  in_sample_out, in_sample_mixed, out_sample, out_sample_valid,
           pipelines_swapping, current_pipeline
  );

  modport slave (
    input  in_sample, in_sample_valid, out_samples_in, out_samples_valid,
           data_in, set_input_gain, set_output_gain, swap_pipelines, swap_target,
    output in_sample_out, in_sample_mixed, out_sample, out_sample_valid,
           pipelines_swapping, current_pipeline
  );
endinterface

// File: rtl/sat_gain_mul.sv
// Registered signed gain multiply: p = sat((a*b) >>> fraction_bits), one cycle latency.
module sat_gain_mul
  import mixer_pkg::*;
#(
  parameter int data_width = 16,
  parameter int gain_shift = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [data_width-1:0] a,
  input  logic signed [data_width-1:0] b,
  output logic signed [data_width-1:0] p
);
  localparam int frac_bits = data_width - 1 - gain_shift;

  logic signed [data_width-1:0] p_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      p_reg <= '0;
    end else begin
      p_reg <= data_width'(saturate((longint'(a) * longint'(b)) >>> frac_bits, data_width));
    end
  end

  assign p = p_reg;
endmodule

// File: rtl/multi_pipeline_mixer.sv
// Input gain, N-way crossfade and output gain around one shared multiplier;
// colliding sample strobes and swap requests are held one-deep (last wins).
module multi_pipeline_mixer
  import mixer_pkg::*;
#(
  parameter int data_width      = 16,
  parameter int gain_shift      = 4,
  parameter int n_pipelines     = 4,
  parameter int fade_step_shift = 7
) (
  input logic clk,
  input logic reset,
  multi_pipeline_mixer_if.slave bus
);
  localparam int idx_w = $clog2(n_pipelines);
  typedef logic signed [data_width-1:0] sample_t;
  typedef logic [data_width:0]          wide_t;
  typedef logic [idx_w-1:0]             idx_t;
  localparam sample_t unity = sample_t'(unity_gain(data_width, gain_shift));
  localparam wide_t   step  = wide_t'(fade_step(data_width, gain_shift, fade_step_shift));

  state_t  state_reg;
  sample_t samples_in [n_pipelines];
  sample_t cap_reg [n_pipelines];
  sample_t out_hold_reg [n_pipelines];
  sample_t in_reg, in_hold_reg, acc_reg;
  sample_t input_gain_reg, output_gain_reg, fade_gain_reg;
  sample_t in_out_reg, out_reg;
  logic    in_pending_reg, out_pending_reg, swap_pending_reg;
  logic    in_mixed_reg, out_valid_reg, swapping_reg;
  idx_t    cur_reg, to_reg, swap_hold_reg;
  sample_t mul_a, mul_b, mul_p, mix_sum;
  wide_t   fade_sum;
  idx_t    swap_sel;
  logic    swap_req, swap_ok;

  generate
    for (genvar gi = 0; gi < n_pipelines; gi++) begin : g_unpack
      assign samples_in[gi] = bus.out_samples_in[gi*data_width +: data_width];
    end
  endgenerate

  sat_gain_mul #(.data_width(data_width), .gain_shift(gain_shift)) u_mul (
    .clk(clk), .reset(reset), .a(mul_a), .b(mul_b), .p(mul_p)
  );

  assign mix_sum  = sample_t'(saturate(longint'(acc_reg) + longint'(mul_p), data_width));
  assign fade_sum = wide_t'(fade_gain_reg) + step;
  assign swap_req = bus.swap_pipelines | swap_pending_reg;
  assign swap_sel = bus.swap_pipelines ? bus.swap_target : swap_hold_reg;
  assign swap_ok  = (swap_sel != cur_reg) && (int'(swap_sel) < n_pipelines);

  // The multiplier's operands are steered by the state it is working for.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_reg)
      IN_MUL:   begin mul_a = in_reg;            mul_b = input_gain_reg;          end
      MIX_FROM: begin mul_a = cap_reg[cur_reg];  mul_b = unity - fade_gain_reg;   end
      MIX_TO:   begin mul_a = cap_reg[to_reg];   mul_b = fade_gain_reg;           end
      OUT_MUL:  begin mul_a = mix_sum;           mul_b = output_gain_reg;         end
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      in_pending_reg   <= 1'b0;
      out_pending_reg  <= 1'b0;
      swap_pending_reg <= 1'b0;
      input_gain_reg   <= unity;
      output_gain_reg  <= unity;
      fade_gain_reg    <= '0;
      cur_reg          <= '0;
      to_reg           <= '0;
      swapping_reg     <= 1'b0;
      in_out_reg       <= '0;
      in_mixed_reg     <= 1'b0;
      out_reg          <= '0;
      out_valid_reg    <= 1'b0;
    end else begin
      in_mixed_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      if (bus.set_input_gain)  input_gain_reg  <= bus.data_in;
      if (bus.set_output_gain) output_gain_reg <= bus.data_in;

      // Swaps only start from IDLE with no fade running; anything else is held.
      if (bus.swap_pipelines && (swapping_reg || state_reg != IDLE)) begin
        swap_pending_reg <= 1'b1;
        swap_hold_reg    <= bus.swap_target;
      end else if (state_reg == IDLE && !swapping_reg && swap_req) begin
        swap_pending_reg <= 1'b0;
        if (swap_ok) begin
          to_reg       <= swap_sel;
          swapping_reg <= 1'b1;
        end
      end

      if (state_reg != IDLE) begin
        if (bus.in_sample_valid) begin
          in_pending_reg <= 1'b1;
          in_hold_reg    <= bus.in_sample;
        end
        if (bus.out_samples_valid) begin
          out_pending_reg <= 1'b1;
          out_hold_reg    <= samples_in;
        end
      end

      case (state_reg)
        IDLE: begin
          if (bus.in_sample_valid || in_pending_reg) begin
            in_reg         <= bus.in_sample_valid ? bus.in_sample : in_hold_reg;
            in_pending_reg <= 1'b0;
            state_reg      <= IN_MUL;
            // The fade advances once per accepted input sample.
            if (swapping_reg) begin
              if (fade_sum >= wide_t'(unity)) begin
                cur_reg       <= to_reg;
                fade_gain_reg <= '0;
                swapping_reg  <= 1'b0;
              end else begin
                fade_gain_reg <= fade_sum[data_width-1:0];
              end
            end
            if (bus.out_samples_valid) begin
              out_pending_reg <= 1'b1;
              out_hold_reg    <= samples_in;
            end
          end else if (bus.out_samples_valid || out_pending_reg) begin
            cap_reg         <= bus.out_samples_valid ? samples_in : out_hold_reg;
            out_pending_reg <= 1'b0;
            state_reg       <= MIX_FROM;
          end
        end
        IN_MUL:   state_reg <= IN_DONE;
        IN_DONE: begin
          in_out_reg   <= mul_p;
          in_mixed_reg <= 1'b1;
          state_reg    <= IDLE;
        end
        MIX_FROM: state_reg <= MIX_TO;
        MIX_TO: begin
          acc_reg   <= mul_p;
          state_reg <= OUT_MUL;
        end
        OUT_MUL:  state_reg <= OUT_DONE;
        OUT_DONE: begin
          out_reg       <= mul_p;
          out_valid_reg <= 1'b1;
          state_reg     <= IDLE;
        end
        default:  state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_sample_out      = in_out_reg;
  assign bus.in_sample_mixed    = in_mixed_reg;
  assign bus.out_sample         = out_reg;
  assign bus.out_sample_valid   = out_valid_reg;
  assign bus.pipelines_swapping = swapping_reg;
  assign bus.current_pipeline   = cur_reg;
endmodule
